// File: rtl/usbfs_pkg.sv
// usbfs_pkg: PID constants, CRC16 helpers and TX state type shared by the USB FS device blocks.
package usbfs_pkg;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_DATA, ST_CRC, ST_FIN} tx_state_t;
    // One serial CRC16 step for a bit taken LSB-first off the wire.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/usbfs_crc16_ser.sv
// usbfs_crc16_ser: serial CRC16 accumulator, one bit per enabled cycle.
module usbfs_crc16_ser
    import usbfs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;
    always_comb crc_d = init ? CRC16_INIT : en ? crc16_step(crc_q, din) : crc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= CRC16_INIT;
        else     crc_q <= crc_d;
    end
    assign crc = crc_q;
endmodule

// File: rtl/usbfs_packet_tx.sv
// usbfs_packet_tx: serialises handshake and data packets (PID, payload, CRC16) LSB-first
// for the bit-level TX layer, with a one-byte holding register in front of the shifter.
module usbfs_packet_tx
    import usbfs_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 64
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       tp_sta,
    input  logic [3:0] tp_pid,
    input  logic       tp_zlp,
    input  logic       tp_byte_en,
    input  logic [7:0] tp_byte,
    input  logic       tp_byte_last,
    output logic       tp_byte_rdy,
    output logic       tp_busy,
    output logic       tp_err,
    output logic       tx_sta,
    input  logic       tx_req,
    output logic       tx_bit,
    output logic       tx_fin
);
    localparam int BCW = $clog2(MAX_PKT_BYTES + 1);
    localparam logic [BCW-1:0] BMAX = BCW'(MAX_PKT_BYTES);

    tx_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d, hold_q, hold_d;
    logic hold_full_q, hold_full_d, hold_last_q, hold_last_d, cur_last_q, cur_last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] crc_cnt_q, crc_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic is_data_q, is_data_d, zlp_q, zlp_d, inv_q, inv_d;
    logic tx_sta_q, tx_sta_d, tx_fin_q, tx_fin_d, tp_err_q, tp_err_d;
    logic [15:0] crc;
    logic shifting, consume, boundary, accept, avail;

    assign shifting    = state_q == ST_PID || state_q == ST_DATA;
    assign consume     = tx_req && shifting;
    assign boundary    = consume && bit_cnt_q == 3'd7;
    assign tp_byte_rdy = shifting && !hold_full_q;
    assign accept      = tp_byte_en && tp_byte_rdy;
    // A byte arriving on the boundary cycle itself is bypassed straight into the shifter.
    assign avail       = hold_full_q || tp_byte_en;
    assign tp_busy     = state_q != ST_IDLE;
    assign tx_bit      = state_q == ST_CRC ? crc[~crc_cnt_q] ^ ~inv_q : tp_busy & shift_q[0];
    assign tx_sta      = tx_sta_q;
    assign tx_fin      = tx_fin_q;
    assign tp_err      = tp_err_q;

    usbfs_crc16_ser u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state_q == ST_IDLE && tp_sta),
        .en   (tx_req && state_q == ST_DATA),
        .din  (shift_q[0]),
        .crc  (crc)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        bit_cnt_d   = bit_cnt_q;
        crc_cnt_d   = crc_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        is_data_d   = is_data_q;
        zlp_d       = zlp_q;
        inv_d       = inv_q;
        tx_sta_d    = 1'b0;
        tx_fin_d    = 1'b0;
        tp_err_d    = 1'b0;
        if (accept) begin
            hold_d      = tp_byte;
            hold_full_d = 1'b1;
            hold_last_d = tp_byte_last;
        end
        if (consume) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        case (state_q)
            ST_IDLE: if (tp_sta) begin
                shift_d     = {~tp_pid, tp_pid};
                bit_cnt_d   = 3'd0;
                crc_cnt_d   = 4'd0;
                byte_cnt_d  = '0;
                hold_full_d = 1'b0;
                cur_last_d  = 1'b0;
                inv_d       = 1'b0;
                is_data_d   = tp_pid[1:0] == 2'b11;
                zlp_d       = tp_zlp;
                tx_sta_d    = 1'b1;
                state_d     = ST_PID;
            end
            ST_PID, ST_DATA: if (boundary) begin
                if (state_q == ST_PID && !is_data_q) begin
                    tx_fin_d = 1'b1;
                    state_d  = ST_FIN;
                end else if ((state_q == ST_PID && zlp_q) || cur_last_q) begin
                    state_d = ST_CRC;
                end else if (byte_cnt_q == BMAX) begin
                    tp_err_d = 1'b1;
                    state_d  = ST_CRC;
                end else if (avail) begin
                    shift_d     = hold_full_q ? hold_q : tp_byte;
                    cur_last_d  = hold_full_q ? hold_last_q : tp_byte_last;
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                    hold_full_d = 1'b0;
                    state_d     = ST_DATA;
                end else begin
                    // Underflow: ship a deliberately wrong CRC so the host drops the packet.
                    tp_err_d = 1'b1;
                    inv_d    = 1'b1;
                    state_d  = ST_CRC;
                end
            end
            ST_CRC: if (tx_req) begin
                crc_cnt_d = crc_cnt_q + 4'd1;
                if (crc_cnt_q == 4'd15) begin
                    tx_fin_d = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            bit_cnt_q   <= '0;
            crc_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            is_data_q   <= 1'b0;
            zlp_q       <= 1'b0;
            inv_q       <= 1'b0;
            tx_sta_q    <= 1'b0;
            tx_fin_q    <= 1'b0;
            tp_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_cnt_q   <= crc_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            is_data_q   <= is_data_d;
            zlp_q       <= zlp_d;
            inv_q       <= inv_d;
            tx_sta_q    <= tx_sta_d;
            tx_fin_q    <= tx_fin_d;
            tp_err_q    <= tp_err_d;
        end
    end
endmodule
